// File: rtl/edubos5_pkg.sv
// Shared types for the EDUBOS5 branch-resolve / writeback stage.
// The instruction kind, branch condition codes, controller states and the
// issue-metadata record all live here so every stage agrees on encodings.
package edubos5_pkg;

    typedef enum logic [1:0] {
        KIND_OP     = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_JAL    = 2'd2,
        KIND_JALR   = 2'd3
    } brwb_kind_t;

    // Codes 010 and 011 are deliberately absent: they never branch.
    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_br_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_KILL = 1'b1
    } brwb_state_t;

    // Return address is always the next sequential instruction.
    localparam logic [31:0] LINK_OFFSET = 32'd4;

    // Issue-time fields held for one cycle while the ALU produces its result.
    typedef struct packed {
        logic        valid;
        brwb_kind_t  kind;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
    } brwb_meta_t;

    // Indirect jumps discard bit 0 of the computed address.
    function automatic logic [31:0] jalr_target(input logic [31:0] base);
        return base & ~32'd1;
    endfunction

endpackage

// File: rtl/edubos5_br_cond.sv
// Branch condition evaluation: maps a branch funct3 code and the ALU compare
// flags onto a single taken bit. Unused codes (010, 011) are never taken.
module edubos5_br_cond
    import edubos5_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       eq,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);

    // Pure decode of the condition code against the compare flags.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = ~eq;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/edubos5_brwb.sv
// EDUBOS5 branch-resolve and writeback stage.
// Issue metadata is parked in a meta register for one cycle so it lines up
// with the ALU result; resolution is combinational from meta + ALU, and all
// outputs are registered (issue-to-output latency of two cycles).
// A redirect squashes the younger instruction sitting in meta and then holds
// off issue for KILL_CYCLES cycles via a RUN/KILL controller.
// Optional feature: define EDUBOS5_MISALIGN_TRAP_EN to turn taken targets
// with bit 1 set into a misalign pulse instead of a redirect.
module edubos5_brwb
    import edubos5_pkg::*;
#(
    parameter int unsigned KILL_CYCLES = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iss_valid,
    input  brwb_kind_t  iss_kind,
    input  logic [2:0]  iss_funct3,
    input  logic [4:0]  iss_rd,
    input  logic [31:0] iss_pc,
    input  logic [31:0] iss_imm,
    input  logic [31:0] alu_out,
    input  logic        eq,
    input  logic        lt,
    input  logic        ltu,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        misalign,
    output logic [31:0] retire_cnt
);

    localparam int unsigned CNT_W = (KILL_CYCLES < 2) ? 1 : $clog2(KILL_CYCLES + 1);

    brwb_meta_t  meta_q, meta_d;
    brwb_state_t state_q;
    logic [CNT_W-1:0] kill_cnt_q;

    logic        br_taken;
    logic        jump;
    logic [31:0] target;
    logic        res_wb;
    logic [31:0] res_data;
    logic        res_redirect;
    logic        res_misalign;
    logic        retire;
    logic        flush;

    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic        redirect_q;
    logic [31:0] redirect_pc_q;
    logic        misalign_q;
    logic [31:0] retire_cnt_q;

    edubos5_br_cond u_br_cond (
        .funct3 (meta_q.funct3),
        .eq     (eq),
        .lt     (lt),
        .ltu    (ltu),
        .taken  (br_taken)
    );

    // Candidate meta contents from the issue port.
    always_comb begin
        meta_d        = '0;
        meta_d.valid  = iss_valid;
        meta_d.kind   = iss_kind;
        meta_d.funct3 = iss_funct3;
        meta_d.rd     = iss_rd;
        meta_d.pc     = iss_pc;
        meta_d.imm    = iss_imm;
    end

    // Resolve the instruction held in meta against this cycle's ALU outputs.
    always_comb begin
        jump         = 1'b0;
        target       = meta_q.pc + meta_q.imm;
        res_wb       = 1'b0;
        res_data     = alu_out;
        res_misalign = 1'b0;
        if (meta_q.valid) begin
            case (meta_q.kind)
                KIND_OP: begin
                    res_wb   = (meta_q.rd != 5'd0);
                    res_data = alu_out;
                end
                KIND_BRANCH: begin
                    jump = br_taken;
                end
                KIND_JAL: begin
                    jump     = 1'b1;
                    res_wb   = (meta_q.rd != 5'd0);
                    res_data = meta_q.pc + LINK_OFFSET;
                end
                default: begin
                    jump     = 1'b1;
                    target   = jalr_target(alu_out);
                    res_wb   = (meta_q.rd != 5'd0);
                    res_data = meta_q.pc + LINK_OFFSET;
                end
            endcase
        end
`ifdef EDUBOS5_MISALIGN_TRAP_EN
        res_misalign = jump & target[1];
`endif
        res_redirect = jump & ~res_misalign;
        if (res_misalign) begin
            res_wb = 1'b0;
        end
        retire = meta_q.valid & ~res_misalign;
        flush  = res_redirect | res_misalign;
    end

    // RUN/KILL controller; owns the meta register so a flush can squash it.
    //   state   | meaning
    //   RUN     | issue accepted into meta each cycle
    //   KILL    | issue ignored, kill counter counting down to 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            kill_cnt_q <= '0;
            meta_q     <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (flush) begin
                        meta_q <= '0;
                        if (KILL_CYCLES != 0) begin
                            state_q    <= ST_KILL;
                            kill_cnt_q <= CNT_W'(KILL_CYCLES);
                        end
                    end else begin
                        meta_q <= meta_d;
                    end
                end
                default: begin
                    meta_q <= '0;
                    if (kill_cnt_q == CNT_W'(1) || kill_cnt_q == '0) begin
                        state_q    <= ST_RUN;
                        kill_cnt_q <= '0;
                    end else begin
                        kill_cnt_q <= kill_cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Register the resolution results; strobes are single-cycle pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= RESET_PC;
            misalign_q    <= 1'b0;
            retire_cnt_q  <= '0;
        end else begin
            wb_valid_q <= res_wb;
            redirect_q <= res_redirect;
            misalign_q <= res_misalign;
            if (res_wb) begin
                wb_rd_q   <= meta_q.rd;
                wb_data_q <= res_data;
            end
            if (res_redirect) begin
                redirect_pc_q <= target;
            end
            if (retire) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
            end
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign misalign    = misalign_q;
    assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_edubos5_brwb.sv
// Testbench for edubos5_brwb: directed scenarios plus a randomized stream
// checked against a cycle-indexed reference model.
module tb_edubos5_brwb;
    import edubos5_pkg::*;

    localparam int unsigned KC  = 2;
    localparam logic [31:0] RPC = 32'h8000_0100;
    localparam int NRAND = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic        iss_valid;
    brwb_kind_t  iss_kind;
    logic [2:0]  iss_funct3;
    logic [4:0]  iss_rd;
    logic [31:0] iss_pc;
    logic [31:0] iss_imm;
    logic [31:0] alu_out;
    logic        eq, lt, ltu;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign;
    logic [31:0] retire_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_ret = 32'd0;

`ifdef EDUBOS5_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    edubos5_brwb #(.KILL_CYCLES(KC), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_kind(iss_kind), .iss_funct3(iss_funct3),
        .iss_rd(iss_rd), .iss_pc(iss_pc), .iss_imm(iss_imm),
        .alu_out(alu_out), .eq(eq), .lt(lt), .ltu(ltu),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .misalign(misalign), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input brwb_kind_t k, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] alu, input logic e, input logic l, input logic lu);
        iss_valid = v; iss_kind = k; iss_funct3 = f3; iss_rd = rd;
        iss_pc = pc; iss_imm = imm; alu_out = alu; eq = e; lt = l; ltu = lu;
    endtask

    task automatic idle(input logic [31:0] alu, input logic e, input logic l, input logic lu);
        drive(1'b0, KIND_OP, 3'd0, 5'd0, 32'd0, 32'd0, alu, e, l, lu);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(32'd0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        n_cmp++;
        if ({wb_valid, redirect, misalign} !== 3'b000) begin
            n_err++; $display("FAIL reset_strobes got=%b exp=000", {wb_valid, redirect, misalign});
        end
        n_cmp++;
        if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            n_err++; $display("FAIL reset_wb got rd=%0d data=%h exp 0/0", wb_rd, wb_data);
        end
        n_cmp++;
        if (redirect_pc !== RPC) begin
            n_err++; $display("FAIL reset_redirect_pc got=%h exp=%h", redirect_pc, RPC);
        end
        n_cmp++;
        if (retire_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_retire got=%0d exp=0", retire_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_ret = 32'd0;
        tick();
    endtask

    task automatic test_op();
        drive(1'b1, KIND_OP, 3'd0, 5'd5, 32'h0000_0200, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle(32'h0000_1234, 1'b0, 1'b0, 1'b0);
        tick();
        exp_ret = exp_ret + 32'd1;
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h1234) begin
            n_err++; $display("FAIL op_wb got v=%b rd=%0d data=%h exp v=1 rd=5 data=00001234", wb_valid, wb_rd, wb_data);
        end
        n_cmp++;
        if (retire_cnt !== exp_ret) begin
            n_err++; $display("FAIL op_retire got=%0d exp=%0d", retire_cnt, exp_ret);
        end
        idle(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (wb_valid !== 1'b0) begin
            n_err++; $display("FAIL op_wb_pulse got=%b exp=0", wb_valid);
        end
    endtask

    task automatic test_beq_kill();
        drive(1'b1, KIND_BRANCH, 3'b000, 5'd0, 32'h100, 32'h20, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, KIND_OP, 3'd0, 5'd7, 32'h104, 32'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        exp_ret = exp_ret + 32'd1;
        n_cmp++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h120 || wb_valid !== 1'b0) begin
            n_err++; $display("FAIL beq_redirect got r=%b pc=%h wb=%b exp r=1 pc=00000120 wb=0", redirect, redirect_pc, wb_valid);
        end
        drive(1'b1, KIND_OP, 3'd0, 5'd8, 32'h108, 32'd0, 32'h1111, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (redirect !== 1'b0 || wb_valid !== 1'b0) begin
            n_err++; $display("FAIL beq_squash got r=%b wb=%b exp 0/0", redirect, wb_valid);
        end
        drive(1'b1, KIND_OP, 3'd0, 5'd9, 32'h10C, 32'd0, 32'h2222, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (wb_valid !== 1'b0) begin
            n_err++; $display("FAIL beq_kill1 got wb=%b exp=0", wb_valid);
        end
        drive(1'b1, KIND_OP, 3'd0, 5'd10, 32'h120, 32'd0, 32'h3333, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (wb_valid !== 1'b0) begin
            n_err++; $display("FAIL beq_kill2 got wb=%b exp=0", wb_valid);
        end
        idle(32'h0000_ABCD, 1'b0, 1'b0, 1'b0);
        tick();
        exp_ret = exp_ret + 32'd1;
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd10 || wb_data !== 32'hABCD || retire_cnt !== exp_ret) begin
            n_err++; $display("FAIL beq_resume got v=%b rd=%0d data=%h ret=%0d exp v=1 rd=10 data=0000abcd ret=%0d",
                              wb_valid, wb_rd, wb_data, retire_cnt, exp_ret);
        end
    endtask

    task automatic test_bltu();
        drive(1'b1, KIND_BRANCH, 3'b110, 5'd0, 32'h300, 32'h40, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, KIND_OP, 3'd0, 5'd3, 32'h304, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        exp_ret = exp_ret + 32'd1;
        n_cmp++;
        if (redirect !== 1'b0 || wb_valid !== 1'b0 || retire_cnt !== exp_ret) begin
            n_err++; $display("FAIL bltu_nt got r=%b wb=%b ret=%0d exp r=0 wb=0 ret=%0d", redirect, wb_valid, retire_cnt, exp_ret);
        end
        idle(32'h0000_0055, 1'b0, 1'b0, 1'b0);
        tick();
        exp_ret = exp_ret + 32'd1;
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h55) begin
            n_err++; $display("FAIL bltu_next_op got v=%b rd=%0d data=%h exp v=1 rd=3 data=00000055", wb_valid, wb_rd, wb_data);
        end
    endtask

    task automatic test_jalr();
        drive(1'b1, KIND_JALR, 3'd0, 5'd1, 32'h400, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle(32'h0000_0203, 1'b0, 1'b0, 1'b0);
        tick();
        if (TRAP) begin
            n_cmp++;
            if (misalign !== 1'b1 || redirect !== 1'b0 || wb_valid !== 1'b0 || retire_cnt !== exp_ret) begin
                n_err++; $display("FAIL jalr_trap got m=%b r=%b wb=%b ret=%0d exp m=1 r=0 wb=0 ret=%0d",
                                  misalign, redirect, wb_valid, retire_cnt, exp_ret);
            end
        end else begin
            exp_ret = exp_ret + 32'd1;
            n_cmp++;
            if (redirect !== 1'b1 || redirect_pc !== 32'h202 || misalign !== 1'b0) begin
                n_err++; $display("FAIL jalr_redirect got r=%b pc=%h m=%b exp r=1 pc=00000202 m=0", redirect, redirect_pc, misalign);
            end
            n_cmp++;
            if (wb_valid !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'h404) begin
                n_err++; $display("FAIL jalr_link got v=%b rd=%0d data=%h exp v=1 rd=1 data=00000404", wb_valid, wb_rd, wb_data);
            end
        end
        idle(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if ({redirect, misalign} !== 2'b00) begin
            n_err++; $display("FAIL jalr_pulse got=%b exp=00", {redirect, misalign});
        end
        tick(); tick();
    endtask

    task automatic test_jal_wrap();
        drive(1'b1, KIND_JAL, 3'd0, 5'd2, 32'hFFFF_FFF0, 32'h20, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        exp_ret = exp_ret + 32'd1;
        n_cmp++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h10) begin
            n_err++; $display("FAIL jal_wrap got r=%b pc=%h exp r=1 pc=00000010", redirect, redirect_pc);
        end
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'hFFFF_FFF4) begin
            n_err++; $display("FAIL jal_link got v=%b rd=%0d data=%h exp v=1 rd=2 data=fffffff4", wb_valid, wb_rd, wb_data);
        end
        tick(); tick(); tick();
        drive(1'b1, KIND_OP, 3'd0, 5'd0, 32'h10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle(32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        tick();
        exp_ret = exp_ret + 32'd1;
        n_cmp++;
        if (wb_valid !== 1'b0 || retire_cnt !== exp_ret) begin
            n_err++; $display("FAIL op_rd0 got wb=%b ret=%0d exp wb=0 ret=%0d", wb_valid, retire_cnt, exp_ret);
        end
    endtask

    task automatic test_reset_in_kill();
        drive(1'b1, KIND_JAL, 3'd0, 5'd6, 32'h40, 32'h8, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h48) begin
            n_err++; $display("FAIL rik_redirect got r=%b pc=%h exp r=1 pc=00000048", redirect, redirect_pc);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({wb_valid, redirect, misalign} !== 3'b000 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            n_err++; $display("FAIL rik_outputs got v=%b r=%b m=%b rd=%0d data=%h exp all 0",
                              wb_valid, redirect, misalign, wb_rd, wb_data);
        end
        n_cmp++;
        if (redirect_pc !== RPC || retire_cnt !== 32'd0) begin
            n_err++; $display("FAIL rik_pc_ret got pc=%h ret=%0d exp pc=%h ret=0", redirect_pc, retire_cnt, RPC);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_ret = 32'd0;
        drive(1'b1, KIND_OP, 3'd0, 5'd4, 32'h80, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle(32'h0000_0077, 1'b0, 1'b0, 1'b0);
        tick();
        exp_ret = exp_ret + 32'd1;
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'h77 || retire_cnt !== exp_ret) begin
            n_err++; $display("FAIL rik_first_issue got v=%b rd=%0d data=%h ret=%0d exp v=1 rd=4 data=00000077 ret=1",
                              wb_valid, wb_rd, wb_data, retire_cnt);
        end
    endtask

    task automatic test_random();
        logic        v_a   [NRAND];
        logic [1:0]  k_a   [NRAND];
        logic [2:0]  f3_a  [NRAND];
        logic [4:0]  rd_a  [NRAND];
        logic [31:0] pc_a  [NRAND];
        logic [31:0] imm_a [NRAND];
        logic [31:0] alu_a [NRAND];
        logic [2:0]  fl_a  [NRAND];
        int          blocked_until;
        logic        e_wb, e_red, e_mis, jmp, tk;
        logic [31:0] e_data, e_tgt;
        logic [2:0]  f3;
        logic [2:0]  fl;

        for (int i = 0; i < NRAND; i++) begin
            v_a[i]   = ($urandom_range(0, 3) != 0);
            k_a[i]   = 2'($urandom_range(0, 3));
            f3_a[i]  = 3'($urandom_range(0, 7));
            rd_a[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pc_a[i]  = $urandom;
            imm_a[i] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
            alu_a[i] = $urandom;
            fl_a[i]  = 3'($urandom_range(0, 7));
        end

        reset = 1'b0;
        idle(32'd0, 1'b0, 1'b0, 1'b0);
        #2;
        @(negedge clk);
        reset = 1'b1;
        exp_ret = 32'd0;
        blocked_until = -1;

        for (int c = 0; c <= NRAND; c++) begin
            if (c < NRAND) begin
                drive(v_a[c], brwb_kind_t'(k_a[c]), f3_a[c], rd_a[c], pc_a[c], imm_a[c], 32'd0, 1'b0, 1'b0, 1'b0);
            end else begin
                idle(32'd0, 1'b0, 1'b0, 1'b0);
            end
            if (c >= 1) begin
                alu_out = alu_a[c-1];
                {eq, lt, ltu} = fl_a[c-1];
            end
            tick();
            if (c >= 1) begin
                int p;
                p = c - 1;
                e_wb = 1'b0; e_red = 1'b0; e_mis = 1'b0; jmp = 1'b0;
                e_data = 32'd0; e_tgt = 32'd0;
                if (v_a[p] && p > blocked_until) begin
                    f3 = f3_a[p];
                    fl = fl_a[p];
                    case (k_a[p])
                        2'd0: begin e_wb = (rd_a[p] != 0); e_data = alu_a[p]; end
                        2'd1: begin
                            case (f3[2:1])
                                2'b00: tk = fl[2];
                                2'b10: tk = fl[1];
                                2'b11: tk = fl[0];
                                default: tk = 1'b0;
                            endcase
                            if (f3[2:1] != 2'b01 && f3[0]) tk = ~tk;
                            jmp = tk;
                            e_tgt = pc_a[p] + imm_a[p];
                        end
                        2'd2: begin
                            jmp = 1'b1; e_tgt = pc_a[p] + imm_a[p];
                            e_wb = (rd_a[p] != 0); e_data = pc_a[p] + 32'd4;
                        end
                        default: begin
                            jmp = 1'b1; e_tgt = {alu_a[p][31:1], 1'b0};
                            e_wb = (rd_a[p] != 0); e_data = pc_a[p] + 32'd4;
                        end
                    endcase
                    e_mis = TRAP && jmp && e_tgt[1];
                    e_red = jmp && !e_mis;
                    if (e_mis) e_wb = 1'b0;
                    if (!e_mis) exp_ret = exp_ret + 32'd1;
                    if (e_red || e_mis) blocked_until = p + 1 + int'(KC);
                end
                n_cmp++;
                if ({wb_valid, redirect, misalign} !== {e_wb, e_red, e_mis}) begin
                    n_err++; $display("FAIL rnd_strobes c=%0d got v/r/m=%b exp=%b", p, {wb_valid, redirect, misalign}, {e_wb, e_red, e_mis});
                end
                n_cmp++;
                if (retire_cnt !== exp_ret) begin
                    n_err++; $display("FAIL rnd_retire c=%0d got=%0d exp=%0d", p, retire_cnt, exp_ret);
                end
                if (e_wb) begin
                    n_cmp++;
                    if (wb_rd !== rd_a[p] || wb_data !== e_data) begin
                        n_err++; $display("FAIL rnd_wb c=%0d got rd=%0d data=%h exp rd=%0d data=%h", p, wb_rd, wb_data, rd_a[p], e_data);
                    end
                end
                if (e_red) begin
                    n_cmp++;
                    if (redirect_pc !== e_tgt) begin
                        n_err++; $display("FAIL rnd_target c=%0d got=%h exp=%h", p, redirect_pc, e_tgt);
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle(32'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_op();
        test_beq_kill();
        test_bltu();
        test_jalr();
        test_jal_wrap();
        test_reset_in_kill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
